arm_multicycle_ctrl: RTL and testbench

Control unit that sequences a multicycle ARM datapath for data-processing, LDR/STR and B instructions, with one shared memory port and one shared ALU. It contains a 10-state main FSM, an ALU decoder, an instruction decoder, and conditional-execution logic with an NZCV flag register. It takes instruction fields from the datapath's instruction register and ALU flags from the ALU. It drives every enable and mux select of the datapath.

---
 rtl/arm_multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl
// Control unit for a multicycle ARM datapath (data-processing, LDR/STR, B)
// with one shared memory port and one shared ALU. Contains the main FSM,
// the ALU decoder, the instruction decoder and conditional-execution logic
// backed by an NZCV flag register.
//
// Ports:
//   clk        - clock, rising-edge active
//   reset      - asynchronous reset, active low
//   Cond       - instr[31:28] condition field
//   Op         - instr[27:26] opcode class
//   Funct      - instr[25:20]: [5]=I, [4:1]=cmd, [0]=S/L
//   Rd         - instr[15:12] destination register
//   ALUFlags   - {N,Z,C,V} produced by the ALU this cycle
//   PCWrite    - PC register enable
//   MemWrite   - memory write enable
//   RegWrite   - register file write enable
//   IRWrite    - instruction register enable
//   AdrSrc     - memory address select (0 = PC, 1 = ALUOut)
//   RegSrc     - register-read address selects
//   ALUSrcA    - ALU A select (0 = RD1, 1 = PC)
//   ALUSrcB    - ALU B select (00 = RD2, 01 = ExtImm, 10 = 4)
//   ResultSrc  - result select (00 = ALUOut, 01 = Data, 10 = ALUResult)
//   ImmSrc     - immediate extender mode
//   ALUControl - 00 ADD, 01 SUB, 10 AND, 11 ORR
//   State      - current FSM state (debug)
module arm_multicycle_ctrl #(
   parameter bit NV_EXECUTES = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] RegSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] ALUControl,
   output logic [3:0] State
);

   localparam int unsigned STATE_W = 4;
   localparam int unsigned FLAG_W  = 4;
   localparam int unsigned CMD_W   = 4;

   typedef enum logic [STATE_W-1:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } stateT;

   stateT              stateQ;
   stateT              stateNext;
   logic [FLAG_W-1:0]  flagsQ;
   logic               condEx;
   logic               condExQ;
   logic               nextPC;
   logic               branch;
   logic               regW;
   logic               memW;
   logic               irW;
   logic               aluOp;
   logic [CMD_W-1:0]   cmd;
   logic               flagN;
   logic               flagZ;
   logic               flagC;
   logic               flagV;
   logic               cvWritable;

   assign cmd                        = Funct[4:1];
   assign {flagN, flagZ, flagC, flagV} = flagsQ;
   assign cvWritable                 = (cmd == 4'b0100) || (cmd == 4'b0010);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ <= FETCH;
      end else begin
         stateQ <= stateNext;
      end
   end

   // Next-state and per-state control decode
   always_comb begin
      stateNext = FETCH;
      nextPC    = 1'b0;
      branch    = 1'b0;
      regW      = 1'b0;
      memW      = 1'b0;
      irW       = 1'b0;
      aluOp     = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      case (stateQ)
         FETCH: begin
            irW       = 1'b1;
            nextPC    = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            stateNext = DECODE;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            case (Op)
               2'b01:   stateNext = MEMADR;
               2'b00:   stateNext = Funct[5] ? EXECI : EXECR;
               2'b10:   stateNext = BRANCH;
               default: stateNext = FETCH;
            endcase
         end
         MEMADR: begin
            ALUSrcB   = 2'b01;
            stateNext = Funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            AdrSrc    = 1'b1;
            stateNext = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            regW      = 1'b1;
            stateNext = FETCH;
         end
         MEMWR: begin
            AdrSrc    = 1'b1;
            memW      = 1'b1;
            stateNext = FETCH;
         end
         EXECR: begin
            ALUSrcB   = 2'b00;
            aluOp     = 1'b1;
            stateNext = ALUWB;
         end
         EXECI: begin
            ALUSrcB   = 2'b01;
            aluOp     = 1'b1;
            stateNext = ALUWB;
         end
         ALUWB: begin
            regW      = 1'b1;
            stateNext = FETCH;
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            branch    = 1'b1;
            stateNext = FETCH;
         end
         default: stateNext = FETCH;
      endcase
   end

   // ALU decoder: address/PC arithmetic always adds
   always_comb begin
      ALUControl = 2'b00;
      if (aluOp) begin
         case (cmd)
            4'b0100: ALUControl = 2'b00;
            4'b0010: ALUControl = 2'b01;
            4'b0000: ALUControl = 2'b10;
            4'b1100: ALUControl = 2'b11;
            default: ALUControl = 2'b00;
         endcase
      end
   end

   // Instruction decoder
   assign ImmSrc = Op;
   assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

   // Condition evaluation on the registered flags
   always_comb begin
      condEx = 1'b0;
      case (Cond)
         4'b0000: condEx = flagZ;
         4'b0001: condEx = !flagZ;
         4'b0010: condEx = flagC;
         4'b0011: condEx = !flagC;
         4'b0100: condEx = flagN;
         4'b0101: condEx = !flagN;
         4'b0110: condEx = flagV;
         4'b0111: condEx = !flagV;
         4'b1000: condEx = flagC && !flagZ;
         4'b1001: condEx = !(flagC && !flagZ);
         4'b1010: condEx = (flagN == flagV);
         4'b1011: condEx = (flagN != flagV);
         4'b1100: condEx = !flagZ && (flagN == flagV);
         4'b1101: condEx = flagZ || (flagN != flagV);
         4'b1110: condEx = 1'b1;
         default: condEx = NV_EXECUTES;
      endcase
   end

   // Flag register; condExQ freezes the decision so an instruction's own
   // flag update cannot alter its writeback
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flagsQ  <= '0;
         condExQ <= 1'b0;
      end else begin
         condExQ <= condEx;
         if (aluOp && Funct[0] && condEx) begin
            flagsQ[3:2] <= ALUFlags[3:2];
            if (cvWritable) begin
               flagsQ[1:0] <= ALUFlags[1:0];
            end
         end
      end
   end

   // Write strobes, all suppressed while reset is held
   assign IRWrite  = reset && irW;
   assign RegWrite = reset && regW && condExQ;
   assign MemWrite = reset && memW && condExQ;
   assign PCWrite  = reset && (nextPC || ((branch || (regW && (Rd == 4'd15))) && condExQ));

   assign State = stateQ;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Testbench for arm_multicycle_ctrl: directed scenarios plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_arm_multicycle_ctrl;

   localparam bit NV = 1'b0;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic       IRWrite;
   logic       AdrSrc;
   logic [1:0] RegSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ImmSrc;
   logic [1:0] ALUControl;
   logic [3:0] State;

   int checks = 0;
   int errors = 0;

   // Reference model state: architectural NZCV flags
   logic [3:0] mFlags = 4'b0000;

   arm_multicycle_ctrl #(.NV_EXECUTES(NV)) dut (
      .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
      .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // ARM condition rules on an NZCV value
   function automatic bit condHolds(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'd0:    return z;
         4'd1:    return !z;
         4'd2:    return cy;
         4'd3:    return !cy;
         4'd4:    return n;
         4'd5:    return !n;
         4'd6:    return v;
         4'd7:    return !v;
         4'd8:    return cy && !z;
         4'd9:    return !cy || z;
         4'd10:   return n == v;
         4'd11:   return n != v;
         4'd12:   return !z && (n == v);
         4'd13:   return z || (n != v);
         4'd14:   return 1'b1;
         default: return NV;
      endcase
   endfunction

   function automatic logic [1:0] aluCode(input logic [3:0] cmd);
      if (cmd == 4'd2)  return 2'b01;
      if (cmd == 4'd0)  return 2'b10;
      if (cmd == 4'd12) return 2'b11;
      return 2'b00;
   endfunction

   // Expected outputs for one cycle of an instruction in phase st
   task automatic checkOutputs(input int st, input bit ex);
      bit wb;
      wb = (st == 4) || (st == 8);
      chk("State",     8'(State),      8'(st));
      chk("IRWrite",   8'(IRWrite),    8'(st == 0));
      chk("PCWrite",   8'(PCWrite),    8'((st == 0) || ((st == 9) && ex) || (wb && ex && (Rd == 4'd15))));
      chk("RegWrite",  8'(RegWrite),   8'(wb && ex));
      chk("MemWrite",  8'(MemWrite),   8'((st == 5) && ex));
      chk("AdrSrc",    8'(AdrSrc),     8'((st == 3) || (st == 5)));
      chk("ALUSrcA",   8'(ALUSrcA),    8'(st <= 1));
      chk("ALUSrcB",   8'(ALUSrcB),    (st <= 1) ? 8'd2 : ((st == 2) || (st == 7) || (st == 9)) ? 8'd1 : 8'd0);
      chk("ResultSrc", 8'(ResultSrc),  ((st <= 1) || (st == 9)) ? 8'd2 : (st == 4) ? 8'd1 : 8'd0);
      chk("ALUCtrl",   8'(ALUControl), ((st == 6) || (st == 7)) ? 8'(aluCode(Funct[4:1])) : 8'd0);
      chk("ImmSrc",    8'(ImmSrc),     8'(Op));
      chk("RegSrc",    8'(RegSrc),     8'({(Op == 2'b01), (Op == 2'b10)}));
   endtask

   task automatic cycle(input int st, input bit ex, input logic [3:0] fl);
      ALUFlags = fl;
      @(negedge clk);
      checkOutputs(st, ex);
      @(posedge clk);
      #1;
   endtask

   // Phase sequence of an instruction class
   function automatic void phases(input logic [1:0] op, input logic [5:0] fn, output int seq[$]);
      case (op)
         2'b01:   seq = fn[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
         2'b00:   seq = fn[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
         2'b10:   seq = '{0, 1, 9};
         default: seq = '{0, 1};
      endcase
   endfunction

   // Run one whole instruction; entered and left at posedge+1 in FETCH
   task automatic runInstr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input bit fixed, input logic [3:0] fixedFl);
      int         seq[$];
      bit         ex;
      logic [3:0] fl;
      logic [3:0] execFl;
      Cond   = c;
      Op     = op;
      Funct  = fn;
      Rd     = rd;
      execFl = 4'b0000;
      ex     = condHolds(c, mFlags);
      phases(op, fn, seq);
      foreach (seq[i]) begin
         fl = fixed ? fixedFl : 4'($urandom);
         if (seq[i] == 6 || seq[i] == 7) execFl = fl;
         cycle(seq[i], ex, fl);
      end
      if (op == 2'b00 && ex && fn[0]) begin
         mFlags[3:2] = execFl[3:2];
         if (fn[4:1] == 4'd4 || fn[4:1] == 4'd2) mFlags[1:0] = execFl[1:0];
      end
   endtask

   initial begin
      logic [3:0] rc;
      logic [1:0] rop;
      logic [5:0] rfn;
      logic [3:0] rrd;

      // Reset held for two edges
      reset    = 1'b0;
      Cond     = 4'hE;
      Op       = 2'b00;
      Funct    = 6'b001000;
      Rd       = 4'd1;
      ALUFlags = 4'b0000;
      repeat (2) begin
         @(negedge clk);
         chk("rst_State",   8'(State),    8'd0);
         chk("rst_PCWrite", 8'(PCWrite),  8'd0);
         chk("rst_IRWrite", 8'(IRWrite),  8'd0);
         chk("rst_RegWrite",8'(RegWrite), 8'd0);
         chk("rst_MemWrite",8'(MemWrite), 8'd0);
         chk("rst_ALUSrcB", 8'(ALUSrcB),  8'd2);
         @(posedge clk);
      end
      #1 reset = 1'b1;

      // Directed scenarios
      runInstr(4'hE, 2'b00, 6'b001000, 4'd1,  1'b1, 4'b1111);   // ADD R-type
      runInstr(4'hE, 2'b01, 6'b011001, 4'd2,  1'b1, 4'b0000);   // LDR
      runInstr(4'hE, 2'b01, 6'b011000, 4'd2,  1'b1, 4'b0000);   // STR
      runInstr(4'hE, 2'b00, 6'b000101, 4'd3,  1'b1, 4'b0110);   // SUBS -> Z,C
      chk("flags_after_subs", 8'(mFlags), 8'h06);
      runInstr(4'h0, 2'b10, 6'b000000, 4'd0,  1'b1, 4'b0000);   // BEQ taken
      runInstr(4'hE, 2'b00, 6'b000101, 4'd3,  1'b1, 4'b0000);   // SUBS -> clear
      runInstr(4'h0, 2'b10, 6'b000000, 4'd0,  1'b1, 4'b0000);   // BEQ not taken
      runInstr(4'hE, 2'b00, 6'b111010, 4'd15, 1'b1, 4'b0000);   // MOV PC, #imm
      runInstr(4'hE, 2'b11, 6'b000000, 4'd0,  1'b1, 4'b0000);   // Op=11
      runInstr(4'hF, 2'b01, 6'b011000, 4'd2,  1'b1, 4'b0000);   // STR never
      runInstr(4'hE, 2'b00, 6'b001001, 4'd4,  1'b1, 4'b1111);   // ADDS all set
      runInstr(4'hE, 2'b00, 6'b100001, 4'd4,  1'b1, 4'b0100);   // ANDS: NZ only
      chk("flags_after_ands", 8'(mFlags), 8'h07);
      runInstr(4'hE, 2'b00, 6'b000101, 4'd5,  1'b1, 4'b0100);   // SUBS -> Z only

      // Reset asserted in the middle of a store
      Cond  = 4'hE;
      Op    = 2'b01;
      Funct = 6'b011000;
      Rd    = 4'd2;
      cycle(0, 1'b1, 4'b0000);
      cycle(1, 1'b1, 4'b0000);
      cycle(2, 1'b1, 4'b0000);
      @(negedge clk);
      checkOutputs(5, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("midrst_State",    8'(State),    8'd0);
      chk("midrst_MemWrite", 8'(MemWrite), 8'd0);
      chk("midrst_PCWrite",  8'(PCWrite),  8'd0);
      chk("midrst_IRWrite",  8'(IRWrite),  8'd0);
      mFlags = 4'b0000;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      runInstr(4'h0, 2'b10, 6'b000000, 4'd0, 1'b1, 4'b0000);    // BEQ after flag clear

      // Randomized instruction stream
      for (int k = 0; k < 150; k++) begin
         rop = 2'($urandom_range(0, 3));
         rfn = 6'($urandom);
         rc  = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
         rrd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
         runInstr(rc, rop, rfn, rrd, 1'b0, 4'b0000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
